xtal_osc_32k_ctrl: RTL

// Startup sequencer and clock-good monitor for the 32 kHz crystal oscillator macro.
// - Drives the oscillator's ena and boost pins.
// - Samples the oscillator's digital output (dout) in the system clock domain.
// - Measures each 32 kHz period and declares the clock good, or declares a startup/loss failure.
// - Sits directly downstream of the oscillator; its status outputs feed the RTC/power-management logic.

---
 rtl/xtal_osc_32k_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/xtal_osc_32k_ctrl.sv
// Startup sequencer and clock-good monitor for the 32 kHz crystal oscillator.
// Drives ena/boost, synchronises dout and qualifies each 32 kHz period.
module xtal_osc_32k_ctrl #(
  parameter int CNT_W        = 24,
  parameter int SYNC_STAGES  = 2,
  parameter int BOOST_CYCLES = 50000,
  parameter int GOOD_EDGES   = 1024,
  parameter int PERIOD_MIN   = 280,
  parameter int PERIOD_MAX   = 330,
  parameter int START_TMO    = 2000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             xtal_dout,
  output logic             xtal_ena,
  output logic             xtal_boost,
  output logic             clk_ok,
  output logic             fail,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] period
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BOOST  = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    FAIL   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] P_MIN      = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] P_MAX      = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] BOOST_LAST = CNT_W'(BOOST_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(START_TMO - 1);
  localparam logic [CNT_W-1:0] GOOD_LAST  = CNT_W'(GOOD_EDGES);

  state_e           state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             dly_q;
  logic             edge_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] boost_q, boost_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             first_q, first_d;
  logic             in_win, per_tmo;

  // Metastability chain, then one delay flop so a rising dout yields a 1-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      sync_q <= {sync_q[SYNC_STAGES-2:0], xtal_dout};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_s  = sync_q[SYNC_STAGES-1] & ~dly_q;
  assign in_win  = (cnt_q >= P_MIN) && (cnt_q <= P_MAX);
  assign per_tmo = (cnt_q > P_MAX);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    good_d   = good_q;
    first_d  = first_q;
    boost_d  = boost_q;
    period_d = period_q;
    tmo_d    = (state_q == SETTLE) ? tmo_q + CNT_W'(1) : '0;
    if (state_q == SETTLE || state_q == RUN)
      cnt_d = edge_s ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
    else
      cnt_d = '0;

    case (state_q)
      IDLE: if (en) begin
        state_d = BOOST;
        boost_d = CNT_W'(1);
      end
      BOOST: if (boost_q >= BOOST_LAST) begin
        state_d = SETTLE;
        boost_d = '0;
        good_d  = '0;
        first_d = 1'b1;
      end else begin
        boost_d = boost_q + CNT_W'(1);
      end
      SETTLE: begin
        // An edge takes priority over a period timeout in the same cycle.
        if (edge_s) begin
          if (first_q) begin
            first_d = 1'b0;
          end else begin
            period_d = cnt_q;
            if (in_win) begin
              good_d = good_q + CNT_W'(1);
            end else begin
              good_d  = '0;
              first_d = 1'b1;
            end
          end
        end else if (per_tmo) begin
          good_d  = '0;
          first_d = 1'b1;
        end
        if (tmo_q >= TMO_LAST)       state_d = FAIL;
        else if (good_d == GOOD_LAST) state_d = RUN;
      end
      RUN: begin
        if (edge_s) begin
          period_d = cnt_q;
          if (!in_win) state_d = FAIL;
        end else if (per_tmo) begin
          state_d = FAIL;
        end
      end
      FAIL: ;
      default: state_d = IDLE;
    endcase

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      tmo_d   = '0;
      boost_d = '0;
      good_d  = '0;
    end
  end

  // Status outputs are registered from the next state so they change with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      good_q     <= '0;
      boost_q    <= '0;
      tmo_q      <= '0;
      period_q   <= '0;
      first_q    <= 1'b0;
      xtal_ena   <= 1'b0;
      xtal_boost <= 1'b0;
      clk_ok     <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      good_q     <= good_d;
      boost_q    <= boost_d;
      tmo_q      <= tmo_d;
      period_q   <= period_d;
      first_q    <= first_d;
      xtal_ena   <= (state_d == BOOST) || (state_d == SETTLE) || (state_d == RUN);
      xtal_boost <= (state_d == BOOST);
      clk_ok     <= (state_d == RUN);
      fail       <= (state_d == FAIL);
    end
  end

  assign state  = state_q;
  assign period = period_q;

endmodule
